// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: FSM states,
// opcode constants and datapath mux-select encodings.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_ECALL  = 7'h73;

    localparam logic [1:0] PC_SRC_PC4    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_ALU    = 2'd2;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_FUNCT  = 2'd1;
    localparam logic [1:0] ALU_BRANCH = 2'd2;

    // Opcodes that proceed past ID; everything else (incl. ECALL) is handled in ID.
    function automatic logic is_exec_op(input logic [6:0] op);
        return (op == OPC_LOAD)   || (op == OPC_STORE) || (op == OPC_OP) ||
               (op == OPC_OP_IMM) || (op == OPC_BRANCH) || (op == OPC_JAL) ||
               (op == OPC_JALR);
    endfunction

endpackage

// File: rtl/mc_control_unit_perf_counters.sv
// Cycle and retired-instruction counters; both wrap modulo 2^CNT_W.
module perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_cycle,
    input  logic             inc_retire,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycle_count   <= '0;
            retired_count <= '0;
        end else begin
            if (inc_cycle)  cycle_count   <= cycle_count + CNT_W'(1);
            if (inc_retire) retired_count <= retired_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM (IF/ID/EX/MEM/WB/HALT) with Moore-decoded
// datapath enables and selects, plus performance counters.
module mc_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             is_itype,
    input  logic             halt_req,
    input  logic             bcond,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             reg_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op_sel,
    output logic [2:0]       state,
    output logic             is_halted,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    state_t state_q, state_d;
    logic   rdy;
    logic   ir_we, mem_we, reg_we, pc_we, retire;

    assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        state_d    = state_q;
        ir_we      = 1'b0;
        mem_read   = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        reg_we     = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_SRC_PC4;
        wb_sel     = WB_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        alu_op_sel = ALU_ADD;
        retire     = 1'b0;
        case (state_q)
            ST_IF: begin
                mem_read = 1'b1;
                ir_we    = rdy;
                if (rdy) state_d = ST_ID;
            end
            ST_ID: begin
                // PC+IMM into ALUOut: branch/JAL target for the EX cycle
                alu_src_b = 1'b1;
                if (opcode == OPC_ECALL && halt_req) begin
                    state_d = ST_HALT;
                end else if (!is_exec_op(opcode)) begin
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    state_d = ST_IF;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                case (opcode)
                    OPC_OP, OPC_OP_IMM: begin
                        alu_src_a  = 1'b1;
                        alu_src_b  = is_itype;
                        alu_op_sel = ALU_FUNCT;
                        state_d    = ST_WB;
                    end
                    OPC_LOAD, OPC_STORE: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                        state_d   = ST_MEM;
                    end
                    OPC_BRANCH: begin
                        alu_src_a  = 1'b1;
                        alu_op_sel = ALU_BRANCH;
                        pc_we      = 1'b1;
                        pc_src     = bcond ? PC_SRC_ALUOUT : PC_SRC_PC4;
                        retire     = 1'b1;
                        state_d    = ST_IF;
                    end
                    OPC_JAL: begin
                        pc_we   = 1'b1;
                        pc_src  = PC_SRC_ALUOUT;
                        reg_we  = 1'b1;
                        wb_sel  = WB_PC4;
                        retire  = 1'b1;
                        state_d = ST_IF;
                    end
                    OPC_JALR: begin
                        alu_src_a = 1'b1;
                        alu_src_b = 1'b1;
                        pc_we     = 1'b1;
                        pc_src    = PC_SRC_ALU;
                        reg_we    = 1'b1;
                        wb_sel    = WB_PC4;
                        retire    = 1'b1;
                        state_d   = ST_IF;
                    end
                    default: state_d = ST_IF;
                endcase
            end
            ST_MEM: begin
                i_or_d    = 1'b1;
                alu_src_a = 1'b1;
                alu_src_b = 1'b1;
                if (opcode == OPC_LOAD) begin
                    mem_read = 1'b1;
                    if (rdy) state_d = ST_WB;
                end else if (opcode == OPC_STORE) begin
                    mem_we = 1'b1;
                    if (rdy) begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = ST_IF;
                    end
                end else begin
                    state_d = ST_IF;
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                wb_sel  = (opcode == OPC_LOAD) ? WB_MDR : WB_ALUOUT;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_d = ST_IF;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IF;
        endcase
    end

    // Architectural writes are suppressed for the whole reset cycle.
    assign ir_write  = ir_we  & reset;
    assign mem_write = mem_we & reset;
    assign reg_write = reg_we & reset;
    assign pc_write  = pc_we  & reset;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_IF;
        else        state_q <= state_d;
    end

    assign state     = state_q;
    assign is_halted = (state_q == ST_HALT);

    perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk           (clk),
        .reset         (reset),
        .inc_cycle     (state_q != ST_HALT),
        .inc_retire    (retire),
        .cycle_count   (cycle_count),
        .retired_count (retired_count)
    );

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multi-cycle control unit for the RV32I core: the sequential replacement for the combinational opcode decoder. It runs an FSM of IF, ID, EX, MEM, WB and HALT states per instruction and drives per-state enables and mux selects into a shared-memory multi-cycle datapath. Memory accesses are stalled on a ready handshake. The unit also keeps cycle and retired-instruction counters for the testbench.

## Interface
Parameters:
- `CNT_W`, default 32: width of both performance counters.
- `MEM_HANDSHAKE`, default 1: 1 means IF and MEM wait for `mem_ready`; 0 means `mem_ready` is ignored and treated as 1.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset; synchronous and active-low.
- `opcode`  in  7  `IR[6:0]`, valid from ID onward.
- `is_itype`  in  1  set for OP-IMM; selects IMM as the EX operand.
- `halt_req`  in  1  `x17 == 10`, sampled in ID for ECALL.
- `bcond`  in  1  ALU branch condition, valid in EX.
- `mem_ready`  in  1  memory has completed the current access.
- `ir_write`, `mem_read`, `mem_write`, `i_or_d`, `reg_write`, `pc_write`  out  1  enables.
- `pc_src`  out  2  next-PC select: 0 = PC+4, 1 = ALUOut, 2 = ALU result.
- `wb_sel`  out  2  write-back select: 0 = ALUOut, 1 = MDR, 2 = PC+4.
- `alu_src_a`  out  1  ALU operand A: 0 = PC, 1 = rs1.
- `alu_src_b`  out  1  ALU operand B: 0 = rs2, 1 = IMM.
- `alu_op_sel`  out  2  ALU operation: 0 = ADD, 1 = FUNCT, 2 = BRANCH.
- `state`  out  3  current FSM state.
- `is_halted`  out  1  sticky halt flag.
- `cycle_count`, `retired_count`  out  `CNT_W`  performance counters.

## Operation
Outputs are Moore-decoded from `state`, qualified by `opcode`, `bcond` and `mem_ready`. Any output not listed for a state is 0.

- **IF:** `mem_read`=1 and `i_or_d`=0. `ir_write`=`mem_ready`. Go to ID when `mem_ready`, otherwise stay in IF.
- **ID:** `alu_src_a`=PC, `alu_src_b`=IMM, `alu_op_sel`=ADD; this latches the branch/JAL target into ALUOut.
  - ECALL with `halt_req` → HALT.
  - ECALL without `halt_req`, or an unknown opcode → treated as NOP: `pc_write`=1, `pc_src`=PC+4, retire, go to IF.
  - Otherwise → EX.
- **EX:** behaviour depends on the instruction class.
  - OP / OP-IMM: A=rs1, B = IMM if `is_itype` else rs2, `alu_op_sel`=FUNCT → WB.
  - LOAD / STORE: rs1+IMM with ADD → MEM.
  - BRANCH: A=rs1, B=rs2, `alu_op_sel`=BRANCH, `pc_write`=1, `pc_src` = `bcond` ? ALUOut : PC+4. Retire → IF.
  - JAL: `pc_write`=1, `pc_src`=ALUOut, `reg_write`=1, `wb_sel`=PC+4. Retire → IF.
  - JALR: rs1+IMM with ADD, `pc_write`=1, `pc_src`=ALU, `reg_write`=1, `wb_sel`=PC+4. Retire → IF. The datapath clears bit 0 of the target.
- **MEM:** `i_or_d`=1 and the ALU inputs are held at the EX values.
  - LOAD: `mem_read`=1; go to WB on `mem_ready`.
  - STORE: `mem_write`=1; on `mem_ready` also `pc_write`=1 and `pc_src`=PC+4, retire → IF.
- **WB:** `reg_write`=1, `wb_sel` = MDR for LOAD else ALUOut, `pc_write`=1, `pc_src`=PC+4. Retire → IF.
- **HALT:** absorbing state with all enables 0 and `is_halted`=1. Only reset leaves it.

Counters:
- `cycle_count` increments every non-reset cycle while not halted.
- `retired_count` increments on every retire cycle.
- Both wrap modulo 2^`CNT_W`.

## Timing
- Reset (`reset`=0 at an edge) sets `state`=IF, both counters to 0 and `is_halted`=0.
- While `reset`=0, all write enables (`ir_write`, `mem_write`, `reg_write`, `pc_write`) are forced to 0. This applies even in the middle of an instruction or during a MEM wait.
- Cycles per instruction with zero-wait memory:
  - branch, JAL, JALR: 3
  - OP, OP-IMM, store: 4
  - load: 5
  - halting ECALL: 2, after which `is_halted`=1
- Each cycle that IF or MEM waits on `mem_ready`=0 adds one cycle. No output changes while waiting.
- `mem_ready` and `bcond` are used combinationally in the same cycle they are sampled.
- A pending `mem_ready` in IF is ignored if reset is asserted in that cycle.
- With `MEM_HANDSHAKE`=0, IF and MEM each take exactly one cycle.

## Structure
- Shared package `mc_ctrl_pkg` holds:
  - the state enum `{IF, ID, EX, MEM, WB, HALT}` (3 bits);
  - the RV32I opcode constants (LOAD 0x03, STORE 0x23, OP 0x33, OP-IMM 0x13, BRANCH 0x63, JAL 0x6F, JALR 0x67, ECALL 0x73);
  - the encodings for `pc_src`, `wb_sel` and `alu_op_sel`.
- One sub-module, `perf_counters`, holds the two `CNT_W` counters with `inc_cycle` and `inc_retire` inputs.
- The FSM and output decode sit in the top module.

## Test plan
- **ADD, zero wait:** `opcode`=0x33 with `mem_ready`=1 → state sequence IF, ID, EX, WB, IF. In WB: `reg_write`=1, `wb_sel`=0, `pc_write`=1, `pc_src`=0. Afterwards `retired_count`=1 and `cycle_count`=4.
- **Load with wait:** `opcode`=0x03, `mem_ready` held 0 for 2 cycles in MEM → MEM occupied for 3 cycles with `mem_read`=1 and `i_or_d`=1, then WB with `wb_sel`=1. The instruction takes 7 cycles in total.
- **Branch taken and not taken:** `opcode`=0x63 with `bcond`=1 → EX shows `pc_src`=1. With `bcond`=0 → EX shows `pc_src`=0. Both take 3 cycles with `pc_write`=1 in EX.
- **JAL and JALR:** EX shows `reg_write`=1 and `wb_sel`=2. `pc_src` is 1 for JAL (0x6F) and 2 for JALR (0x67).
- **ECALL:** `opcode`=0x73 with `halt_req`=1 → HALT; `is_halted` stays 1 for 10 further cycles and `cycle_count` stays frozen. With `halt_req`=0 → retired as a NOP in ID.
- **Reset mid-MEM:** assert `reset`=0 during a store wait → `mem_write`=0 and `pc_write`=0 that cycle. At the next edge: `state`=IF and both counters 0.
